// File: rtl/pupil_pkg.sv
// rtl/pupil_pkg.sv - shared constants and FSM state type for the pupil locator
package pupil_pkg;
    localparam int COORD_W = 13;
    localparam int PIX_W   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIVX = 2'd1,
        DIVY = 2'd2,
        PUB  = 2'd3
    } state_t;
endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - restoring divider, one load cycle then N quotient-bit cycles
module serial_divider #(
    parameter int N = 28,
    parameter int D = 15
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic         iSTART,
    input  logic [N-1:0] iNUM,
    input  logic [D-1:0] iDEN,
    output logic [N-1:0] oQ,
    output logic         oBUSY,
    output logic         oDONE
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  q_q;
    logic [D-1:0]  rem_q;
    logic [D-1:0]  den_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [D:0]    cand;
    logic [D+1:0]  diff;
    logic          unused_diff;

    // Remainder stays below the divisor, so the trial value never exceeds 2*den.
    assign cand        = {rem_q, q_q[N-1]};
    assign diff        = {1'b0, cand} - {2'b0, den_q};
    assign unused_diff = diff[D];

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            q_q    <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (iSTART) begin
            q_q    <= iNUM;
            rem_q  <= '0;
            den_q  <= iDEN;
            cnt_q  <= CW'(N);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            q_q   <= {q_q[N-2:0], ~diff[D+1]};
            rem_q <= diff[D+1] ? cand[D-1:0] : diff[D-1:0];
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1))
                busy_q <= 1'b0;
        end
    end

    // Asserted during the final iteration; oQ is complete after the next edge.
    assign oQ    = q_q;
    assign oBUSY = busy_q;
    assign oDONE = busy_q && (cnt_q == CW'(1));
endmodule

// File: rtl/pupil_locator.sv
// rtl/pupil_locator.sv - per-frame dark-pixel statistics and centroid from a raster stream
module pupil_locator
    import pupil_pkg::*;
#(
    parameter int              IMG_W  = 128,
    parameter int              IMG_H  = 128,
    parameter logic [PIX_W-1:0] THRESH = 10'd128,
    localparam int             NW     = $clog2(IMG_W * IMG_H + 1),
    localparam int             SW     = 13 + NW
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iDVAL,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    input  logic [PIX_W-1:0]   iVAL,
    output logic [COORD_W-1:0] oCX,
    output logic [COORD_W-1:0] oCY,
    output logic [COORD_W-1:0] oMINX,
    output logic [COORD_W-1:0] oMAXX,
    output logic [COORD_W-1:0] oMINY,
    output logic [COORD_W-1:0] oMAXY,
    output logic [NW-1:0]      oCOUNT,
    output logic               oFOUND,
    output logic               oDONE,
    output logic               oOVR
);
    logic               dark, fstart, fend, end_q;
    logic [NW-1:0]      cnt_q, scnt_q;
    logic [SW-1:0]      sumx_q, sumy_q, ssumy_q;
    logic [COORD_W-1:0] minx_q, maxx_q, miny_q, maxy_q;
    logic [COORD_W-1:0] sminx_q, smaxx_q, sminy_q, smaxy_q, qx_q;
    state_t             state_q;
    logic               div_start, div_busy, div_done;
    logic [SW-1:0]      div_num, div_q;
    logic [NW-1:0]      div_den;
    logic               unused_q;

    assign dark   = iVAL < THRESH;
    assign fstart = (iX == '0) && (iY == '0);
    assign fend   = (iX == COORD_W'(IMG_W - 1)) && (iY == COORD_W'(IMG_H - 1));

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            end_q  <= 1'b0;
            cnt_q  <= '0;
            sumx_q <= '0;
            sumy_q <= '0;
            minx_q <= '0;
            maxx_q <= '0;
            miny_q <= '0;
            maxy_q <= '0;
        end else begin
            end_q <= iDVAL && fend;
            if (iDVAL) begin
                if (fstart) begin
                    cnt_q  <= {{(NW-1){1'b0}}, dark};
                    sumx_q <= dark ? SW'(iX) : '0;
                    sumy_q <= dark ? SW'(iY) : '0;
                    minx_q <= dark ? iX : '0;
                    maxx_q <= dark ? iX : '0;
                    miny_q <= dark ? iY : '0;
                    maxy_q <= dark ? iY : '0;
                end else if (dark) begin
                    cnt_q  <= cnt_q + NW'(1);
                    sumx_q <= sumx_q + SW'(iX);
                    sumy_q <= sumy_q + SW'(iY);
                    // An empty count means the box holds no dark pixel yet.
                    if (cnt_q == '0) begin
                        minx_q <= iX;
                        maxx_q <= iX;
                        miny_q <= iY;
                        maxy_q <= iY;
                    end else begin
                        if (iX < minx_q) minx_q <= iX;
                        if (iX > maxx_q) maxx_q <= iX;
                        if (iY < miny_q) miny_q <= iY;
                        if (iY > maxy_q) maxy_q <= iY;
                    end
                end
            end
        end
    end

    // X divide loads straight from the accumulators on the snapshot edge.
    assign div_start = (state_q == IDLE && end_q && cnt_q != '0) || (state_q == DIVY && !div_busy);
    assign div_num   = (state_q == IDLE) ? sumx_q : ssumy_q;
    assign div_den   = (state_q == IDLE) ? cnt_q : scnt_q;
    assign unused_q  = ^div_q[SW-1:COORD_W];

    serial_divider #(.N(SW), .D(NW)) u_div (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iSTART (div_start),
        .iNUM   (div_num),
        .iDEN   (div_den),
        .oQ     (div_q),
        .oBUSY  (div_busy),
        .oDONE  (div_done)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            ssumy_q <= '0;
            sminx_q <= '0;
            smaxx_q <= '0;
            sminy_q <= '0;
            smaxy_q <= '0;
            qx_q    <= '0;
            oCX     <= '0;
            oCY     <= '0;
            oMINX   <= '0;
            oMAXX   <= '0;
            oMINY   <= '0;
            oMAXY   <= '0;
            oCOUNT  <= '0;
            oFOUND  <= 1'b0;
            oDONE   <= 1'b0;
            oOVR    <= 1'b0;
        end else begin
            oDONE <= 1'b0;
            oOVR  <= end_q && (state_q != IDLE);
            case (state_q)
                IDLE: if (end_q) begin
                    scnt_q  <= cnt_q;
                    ssumy_q <= sumy_q;
                    sminx_q <= minx_q;
                    smaxx_q <= maxx_q;
                    sminy_q <= miny_q;
                    smaxy_q <= maxy_q;
                    state_q <= (cnt_q != '0) ? DIVX : PUB;
                end
                DIVX: if (div_done) state_q <= DIVY;
                DIVY: begin
                    if (!div_busy) qx_q <= div_q[COORD_W-1:0];
                    if (div_done) state_q <= PUB;
                end
                PUB: begin
                    oFOUND  <= scnt_q != '0;
                    oCX     <= (scnt_q != '0) ? qx_q : '0;
                    oCY     <= (scnt_q != '0) ? div_q[COORD_W-1:0] : '0;
                    oMINX   <= (scnt_q != '0) ? sminx_q : '0;
                    oMAXX   <= (scnt_q != '0) ? smaxx_q : '0;
                    oMINY   <= (scnt_q != '0) ? sminy_q : '0;
                    oMAXY   <= (scnt_q != '0) ? smaxy_q : '0;
                    oCOUNT  <= scnt_q;
                    oDONE   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
